cal_lut_tx: RTL and testbench

CAL_LUT_TX -- requirements
Module: cal_lut_tx

---
 rtl/cal_lut_tx.sv | 166 ++++++++++++++++
 tb/tb_cal_lut_tx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_lut_tx.sv
// cal_lut_tx: serializes one session of N_ENTRIES calibration LUT entries
// (N_LUT bits each) onto a sensor's three-wire calibration port.
//
// Ports:
//   clk, rst_n       system clock (rising edge), async active-low reset
//   start, abort     begin a load session / terminate the session in progress
//   s_data, s_valid  entry stream input, entries supplied from index
//   s_ready          N_ENTRIES-1 down to 0; s_ready high only while waiting
//   cal_clk, cal_dat serial shift clock and data (sensor samples on cal_clk rise)
//   cal_ena          LUT-apply enable, set when a session completes
//   busy, done       session in progress / one-cycle completion pulse
//   entry_idx        LUT index of the next entry expected
module cal_lut_tx #(
  parameter int unsigned N_LUT     = 7,
  parameter int unsigned N_ENTRIES = 128,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [N_LUT-1:0]             s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         cal_clk,
  output logic                         cal_dat,
  output logic                         cal_ena,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_ENTRIES)-1:0] entry_idx
);

  localparam int unsigned IW       = $clog2(N_ENTRIES);
  localparam int unsigned BW       = (N_LUT > 1) ? $clog2(N_LUT) : 1;
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SHIFT_LO,
    SHIFT_HI,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [N_LUT-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [7:0]       div_q, div_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cal_dat_q, cal_dat_d;
  logic             cal_ena_q, cal_ena_d;
  logic             cal_clk_q, cal_clk_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    div_d     = div_q;
    idx_d     = idx_q;
    cal_dat_d = cal_dat_q;
    cal_ena_d = cal_ena_q;

    if (abort && (state_q != IDLE)) begin
      // abort outranks start and any transfer offered in the same cycle
      state_d   = IDLE;
      cal_ena_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = WAIT_DATA;
            idx_d     = IW'(N_ENTRIES - 1);
            bit_d     = '0;
            cal_ena_d = 1'b0;
          end
        end
        WAIT_DATA: begin
          if (s_valid) begin
            state_d   = SHIFT_LO;
            sh_d      = s_data;
            cal_dat_d = s_data[N_LUT-1];
            bit_d     = BW'(N_LUT - 1);
            div_d     = '0;
          end
        end
        SHIFT_LO: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            state_d = SHIFT_HI;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (bit_q != '0) begin
              // next bit goes out on the same edge cal_clk falls
              state_d   = SHIFT_LO;
              bit_d     = bit_q - BW'(1);
              sh_d      = sh_q << 1;
              cal_dat_d = sh_d[N_LUT-1];
            end else if (idx_q != '0) begin
              state_d = WAIT_DATA;
              idx_d   = idx_q - IW'(1);
            end else begin
              state_d   = FINISH;
              cal_ena_d = 1'b1;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Strobes are registered copies of the next state so each output is a
    // single flop with no decode glitches.
    cal_clk_d = (state_d == SHIFT_HI);
    s_ready_d = (state_d == WAIT_DATA);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      cal_dat_q <= 1'b0;
      cal_ena_q <= 1'b0;
      cal_clk_q <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      cal_dat_q <= cal_dat_d;
      cal_ena_q <= cal_ena_d;
      cal_clk_q <= cal_clk_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign cal_clk   = cal_clk_q;
  assign cal_dat   = cal_dat_q;
  assign cal_ena   = cal_ena_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign entry_idx = idx_q;

endmodule

// File: tb/tb_cal_lut_tx.sv
// tb_cal_lut_tx: drives cal_lut_tx load sessions and checks the serial
// stream against a model of the sensor's LUT shift register.
module tb_cal_lut_tx;

  localparam int unsigned NL   = 7;
  localparam int unsigned NE   = 128;
  localparam int unsigned CD   = 2;
  localparam int unsigned NB   = NL * NE;
  localparam int unsigned NE_F = 4;
  localparam int unsigned CD_F = 1;
  localparam int unsigned NB_F = NL * NE_F;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic s_valid = 1'b0;
  logic [NL-1:0] s_data = '0;
  logic s_ready, cal_clk, cal_dat, cal_ena, busy, done;
  logic [6:0] entry_idx;

  logic f_start = 1'b0;
  logic [NL-1:0] f_data;
  logic f_ready, f_clk, f_dat, f_ena, f_busy, f_done;
  logic [1:0] f_idx;
  logic [NL-1:0] f_tab [NE_F];
  logic f_valid = 1'b1;
  logic f_abort = 1'b0;

  assign f_data = f_tab[f_idx];

  always #5 clk = ~clk;

  cal_lut_tx #(.N_LUT(NL), .N_ENTRIES(NE), .CLK_DIV(CD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cal_clk(cal_clk), .cal_dat(cal_dat), .cal_ena(cal_ena),
    .busy(busy), .done(done), .entry_idx(entry_idx)
  );

  cal_lut_tx #(.N_LUT(NL), .N_ENTRIES(NE_F), .CLK_DIV(CD_F)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .start(f_start), .abort(f_abort),
    .s_data(f_data), .s_valid(f_valid), .s_ready(f_ready),
    .cal_clk(f_clk), .cal_dat(f_dat), .cal_ena(f_ena),
    .busy(f_busy), .done(f_done), .entry_idx(f_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Sensor model: shift register clocked by cal_clk rising edges.
  logic [NB-1:0] sens = '0;
  int   rises = 0, dones = 0;
  logic clk_prev = 1'b0, dat_prev = 1'b0;
  int   dat_age = 0, per_cyc = 0, hi_len = 0;
  bit   gap_seen = 1'b1;

  always @(negedge clk) begin
    dat_age = (cal_dat !== dat_prev) ? 1 : dat_age + 1;
    per_cyc++;
    if (done) dones++;
    if (cal_clk) begin
      check("dat_hold_hi", 32'(cal_dat), 32'(dat_prev));
      hi_len++;
    end
    if (cal_clk && !clk_prev) begin
      rises++;
      sens = {sens[NB-2:0], cal_dat};
      check("dat_setup", 32'(dat_age > int'(CD)), 32'd1);
      if (!gap_seen) check("bit_period", 32'(per_cyc), 32'(2 * CD));
      per_cyc  = 0;
      gap_seen = 1'b0;
    end
    if (!cal_clk && clk_prev && busy) check("clk_hi_len", 32'(hi_len), 32'(CD));
    if (!cal_clk) hi_len = 0;
    if (s_ready || !busy) begin
      gap_seen = 1'b1;
      check("clk_low_idle", 32'(cal_clk), 32'd0);
    end
    clk_prev = cal_clk;
    dat_prev = cal_dat;
  end

  logic [NB_F-1:0] f_sens = '0;
  int   f_rises = 0, f_dones = 0, f_per = 0;
  logic f_clk_prev = 1'b0;
  bit   f_gap = 1'b1;

  always @(negedge clk) begin
    f_per++;
    if (f_done) f_dones++;
    if (f_clk && !f_clk_prev) begin
      f_rises++;
      f_sens = {f_sens[NB_F-2:0], f_dat};
      if (!f_gap) check("fast_period", 32'(f_per), 32'(2 * CD_F));
      f_per = 0;
      f_gap = 1'b0;
    end
    if (f_ready || !f_busy) f_gap = 1'b1;
    f_clk_prev = f_clk;
  end

  logic [NL-1:0] exp_lut [NE];

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    nstep();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!s_ready && t < 400) begin
      nstep();
      t++;
    end
    check("ready_timeout", 32'(s_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 600) begin
      nstep();
      t++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send_entry(input int idx, input logic [NL-1:0] v);
    s_valid = 1'b1;
    s_data  = v;
    wait_ready();
    check("entry_idx", 32'(entry_idx), 32'(idx));
    nstep();
    s_valid = 1'b0;
    check("msb_first", 32'(cal_dat), 32'(v[NL-1]));
  endtask

  task automatic full_load(input int gap_idx, input int start_idx, input bit rnd);
    int br, bd;
    for (int i = 0; i < int'(NE); i++)
      exp_lut[i] = rnd ? NL'($urandom) : (NL'(i) ^ 7'h55);
    br = rises;
    bd = dones;
    pulse_start();
    check("busy_start", 32'(busy), 32'd1);
    check("ena_drop", 32'(cal_ena), 32'd0);
    check("idx_load", 32'(entry_idx), 32'(NE - 1));
    for (int i = int'(NE) - 1; i >= 0; i--) begin
      if (i == gap_idx) begin
        s_valid = 1'b0;
        wait_ready();
        for (int k = 0; k < 20; k++) begin
          check("bp_clk_low", 32'(cal_clk), 32'd0);
          nstep();
        end
        check("bp_no_edge", 32'(rises - br), 32'((int'(NE) - 1 - i) * int'(NL)));
      end
      send_entry(i, exp_lut[i]);
      if (i == start_idx) begin
        pulse_start();
        check("start_ignored_idx", 32'(entry_idx), 32'(i));
      end
    end
    wait_idle();
    check("rise_count", 32'(rises - br), 32'(NB));
    check("done_count", 32'(dones - bd), 32'd1);
    check("cal_ena_set", 32'(cal_ena), 32'd1);
    for (int i = 0; i < int'(NE); i++)
      check("lut_slice", 32'(sens[i*NL +: NL]), 32'(exp_lut[i]));
  endtask

  task automatic abort_test();
    int br, bd, r, t;
    br = rises;
    bd = dones;
    pulse_start();
    for (int i = int'(NE) - 1; i >= 50; i--) send_entry(i, NL'($urandom));
    t = 0;
    while (!(cal_clk && (rises - br) == (int'(NE) - 1 - 50) * int'(NL) + 4) && t < 200) begin
      nstep();
      t++;
    end
    check("abort_reach", 32'(cal_clk), 32'd1);
    abort = 1'b1;
    nstep();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_clk", 32'(cal_clk), 32'd0);
    check("abort_ena", 32'(cal_ena), 32'd0);
    check("abort_ready", 32'(s_ready), 32'd0);
    r = rises;
    repeat (30) nstep();
    check("abort_no_edge", 32'(rises - r), 32'd0);
    check("abort_no_done", 32'(dones - bd), 32'd0);
  endtask

  task automatic sim_abort_test();
    int bd, r;
    logic d;
    bd = dones;
    pulse_start();
    for (int i = int'(NE) - 1; i >= 120; i--) send_entry(i, NL'($urandom));
    s_valid = 1'b0;
    wait_ready();
    d       = cal_dat;
    s_data  = {~cal_dat, 6'($urandom)};
    s_valid = 1'b1;
    abort   = 1'b1;
    nstep();
    abort   = 1'b0;
    s_valid = 1'b0;
    check("simab_busy", 32'(busy), 32'd0);
    check("simab_ready", 32'(s_ready), 32'd0);
    check("simab_clk", 32'(cal_clk), 32'd0);
    r = rises;
    repeat (10) nstep();
    check("simab_no_edge", 32'(rises - r), 32'd0);
    check("simab_no_capture", 32'(cal_dat), 32'(d));
    check("simab_no_done", 32'(dones - bd), 32'd0);
  endtask

  task automatic reset_test();
    int r, t;
    pulse_start();
    for (int i = int'(NE) - 1; i >= 125; i--) send_entry(i, 7'h7f);
    t = 0;
    while (!cal_clk && t < 50) begin
      nstep();
      t++;
    end
    check("rst_reach_hi", 32'(cal_clk), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_clk", 32'(cal_clk), 32'd0);
    check("rst_dat", 32'(cal_dat), 32'd0);
    check("rst_ena", 32'(cal_ena), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(entry_idx), 32'd0);
    r = rises;
    repeat (3) nstep();
    rst_n = 1'b1;
    repeat (30) nstep();
    check("rst_no_edge", 32'(rises - r), 32'd0);
    check("rst_stay_idle", 32'(busy), 32'd0);
  endtask

  task automatic fast_test();
    int br, bd, t;
    br = f_rises;
    bd = f_dones;
    f_start = 1'b1;
    nstep();
    f_start = 1'b0;
    t = 0;
    while (f_busy && t < 200) begin
      nstep();
      t++;
    end
    check("fast_idle", 32'(f_busy), 32'd0);
    check("fast_rises", 32'(f_rises - br), 32'(NB_F));
    check("fast_done", 32'(f_dones - bd), 32'd1);
    check("fast_ena", 32'(f_ena), 32'd1);
    for (int i = 0; i < int'(NE_F); i++)
      check("fast_slice", 32'(f_sens[i*NL +: NL]), 32'(f_tab[i]));
  endtask

  initial begin
    for (int i = 0; i < int'(NE_F); i++) f_tab[i] = NL'($urandom);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_clk", 32'(cal_clk), 32'd0);
    check("reset_dat", 32'(cal_dat), 32'd0);
    check("reset_ena", 32'(cal_ena), 32'd0);
    check("reset_ready", 32'(s_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_idx", 32'(entry_idx), 32'd0);
    repeat (3) nstep();
    rst_n = 1'b1;
    nstep();

    fast_test();
    full_load(-1, -1, 1'b0);

    abort = 1'b1;
    nstep();
    abort = 1'b0;
    nstep();
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_ena", 32'(cal_ena), 32'd1);

    full_load(64, 10, 1'b0);
    abort_test();
    full_load(-1, -1, 1'b1);
    sim_abort_test();
    reset_test();
    full_load(-1, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
